adc_frontend: RTL and testbench

- Upstream stage of the second-order IIR filter path.
- Generates the ADC sample clock from the 12 MHz system clock and captures the 8-bit offset-binary ADC word at a fixed phase of each sample period.
- Converts each word to two's complement, box-car averages 2^DECIM_LOG2 samples (decimation), and queues the results in a small FIFO.
- The filter consumes the FIFO through a valid/ready handshake.

---
 rtl/adc_frontend.sv | 128 ++++++++++++
 tb/tb_adc_frontend.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_frontend.sv
// ADC front end: divided sample clock, fixed-phase capture, box-car decimation, small output FIFO.
// Result is visible one cycle after its push edge; a full FIFO with no pop drops the result and sets overflow.
module adc_frontend #(
  parameter int CLK_DIV       = 12,
  parameter int CAPTURE_PHASE = 8,
  parameter int DECIM_LOG2    = 2,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] adc_data,
  output logic       adc_clk,
  output logic [7:0] sample_data,
  output logic       sample_valid,
  input  logic       sample_ready,
  output logic       overflow,
  input  logic       clr_overflow
);

  localparam int PCW = $clog2(CLK_DIV);
  localparam int CW  = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam int AW  = 8 + DECIM_LOG2;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int GRP = 1 << DECIM_LOG2;

  logic [PCW-1:0]       phase_q, phase_d;
  logic                 adc_clk_q, adc_clk_d;
  logic [7:0]           cap_q, cap_d;
  logic                 cap_vld_q, cap_vld_d;
  logic [CW-1:0]        ccnt_q, ccnt_d;
  logic signed [AW-1:0] acc_q, acc_d, sum;
  logic                 push;
  logic [7:0]           push_dat;

  logic [7:0]           mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wr_q, rd_q;
  logic [PW:0]          fcnt_q, fcnt_d;
  logic                 ovf_q, ovf_d;
  logic                 pop, full, do_push, drop;

  always_comb begin
    phase_d   = phase_q;
    adc_clk_d = adc_clk_q;
    cap_d     = cap_q;
    cap_vld_d = 1'b0;
    ccnt_d    = ccnt_q;
    acc_d     = acc_q;
    push      = 1'b0;
    sum       = acc_q + AW'($signed(cap_q));
    push_dat  = 8'(sum >>> DECIM_LOG2);
    // Disabling flushes the partial group and any capture still waiting to be accumulated.
    if (!enable) begin
      phase_d   = '0;
      adc_clk_d = 1'b0;
      ccnt_d    = '0;
      acc_d     = '0;
    end else begin
      phase_d   = (phase_q == PCW'(CLK_DIV - 1)) ? '0 : phase_q + 1'b1;
      adc_clk_d = (phase_q < PCW'(CLK_DIV / 2));
      if (phase_q == PCW'(CAPTURE_PHASE)) begin
        cap_vld_d = 1'b1;
        cap_d     = adc_data ^ 8'h80;
      end
      if (cap_vld_q) begin
        if (ccnt_q == CW'(GRP - 1)) begin
          push   = 1'b1;
          acc_d  = '0;
          ccnt_d = '0;
        end else begin
          acc_d  = sum;
          ccnt_d = ccnt_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    pop     = (fcnt_q != '0) && sample_ready;
    full    = (fcnt_q == (PW + 1)'(FIFO_DEPTH));
    do_push = push && (!full || pop);
    drop    = push && full && !pop;
    fcnt_d  = fcnt_q;
    case ({do_push, pop})
      2'b10:   fcnt_d = fcnt_q + 1'b1;
      2'b01:   fcnt_d = fcnt_q - 1'b1;
      default: fcnt_d = fcnt_q;
    endcase
    // A drop on the same edge as a clear keeps the flag set.
    ovf_d = drop ? 1'b1 : (clr_overflow ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= '0;
      adc_clk_q <= 1'b0;
      cap_q     <= '0;
      cap_vld_q <= 1'b0;
      ccnt_q    <= '0;
      acc_q     <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      fcnt_q    <= '0;
      ovf_q     <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      phase_q   <= phase_d;
      adc_clk_q <= adc_clk_d;
      cap_q     <= cap_d;
      cap_vld_q <= cap_vld_d;
      ccnt_q    <= ccnt_d;
      acc_q     <= acc_d;
      fcnt_q    <= fcnt_d;
      ovf_q     <= ovf_d;
      if (do_push) begin
        mem_q[wr_q] <= push_dat;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
    end
  end

  assign adc_clk      = adc_clk_q;
  assign sample_data  = mem_q[rd_q];
  assign sample_valid = (fcnt_q != '0);
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_adc_frontend.sv
// Bench for adc_frontend: directed scenarios plus random traffic against a queue-based reference model.
module tb_adc_frontend;

  localparam int CLK_DIV = 12;
  localparam int CAP     = 8;
  localparam int GRP     = 4;
  localparam int DEPTH   = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, rdy, clr;
  logic [7:0] din;
  logic       adc_clk, sample_valid, overflow;
  logic [7:0] sample_data;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: samples as signed integers, FIFO as a queue.
  int         m_grp[$];
  logic [7:0] m_q[$];
  bit         m_pend;
  int         m_pend_val;
  bit         m_ovf;
  bit         m_adc;
  int         m_ecyc;

  always #5 clk = ~clk;

  adc_frontend #(.CLK_DIV(CLK_DIV), .CAPTURE_PHASE(CAP), .DECIM_LOG2(2), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .enable(en), .adc_data(din), .adc_clk(adc_clk),
    .sample_data(sample_data), .sample_valid(sample_valid), .sample_ready(rdy),
    .overflow(overflow), .clr_overflow(clr)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_grp.delete(); m_q.delete();
    m_pend = 0; m_pend_val = 0; m_ovf = 0; m_adc = 0; m_ecyc = 0;
  endtask

  // Advance model and DUT across one clock edge using the currently driven inputs.
  task automatic step();
    int res, sum, nval;
    bit push, pop, drop, npend;
    pop = (m_q.size() != 0) && rdy;
    push = 0; res = 0; npend = 0; nval = 0; sum = 0;
    if (en) begin
      if (m_pend) begin
        m_grp.push_back(m_pend_val);
        if (m_grp.size() == GRP) begin
          foreach (m_grp[i]) sum += m_grp[i];
          res = sum / GRP;
          if ((sum % GRP) != 0 && sum < 0) res -= 1;
          push = 1;
          m_grp.delete();
        end
      end
      npend = ((m_ecyc % CLK_DIV) == CAP);
      nval  = int'(din) - 128;
      m_adc = ((m_ecyc % CLK_DIV) < CLK_DIV / 2);
      m_ecyc++;
    end else begin
      m_grp.delete();
      m_adc = 0;
      m_ecyc = 0;
    end
    drop = push && !pop && (m_q.size() == DEPTH);
    if (pop) void'(m_q.pop_front());
    if (push && !drop) m_q.push_back(8'(res));
    if (drop) m_ovf = 1;
    else if (clr) m_ovf = 0;
    m_pend = npend;
    m_pend_val = nval;
    @(posedge clk);
    #1;
  endtask

  task automatic quiesce();
    en = 0; rdy = 1; clr = 1;
    repeat (6) step();
    rdy = 0; clr = 0;
  endtask

  task automatic test_reset();
    rst_n = 1; en = 1; din = 8'hC0; rdy = 0; clr = 0;
    #2 rst_n = 0;
    #2;
    vectors++; if (adc_clk !== 1'b0) begin miscompares++; $display("FAIL rst_adc_clk got=%b exp=0", adc_clk); end
    vectors++; if (sample_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got=%b exp=0", sample_valid); end
    vectors++; if (sample_data !== 8'h00) begin miscompares++; $display("FAIL rst_data got=%h exp=00", sample_data); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL rst_overflow got=%b exp=0", overflow); end
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (adc_clk !== 1'b0) begin miscompares++; $display("FAIL rst_hold_adc_clk got=%b exp=0", adc_clk); end
    en = 0;
    @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  task automatic test_const_c0();
    int first, hi;
    int pops[$];
    quiesce();
    din = 8'hC0; rdy = 0; en = 1; first = -1; hi = 0;
    for (int k = 1; k <= 60; k++) begin
      step();
      if (k >= 13 && k <= 24) hi += int'(adc_clk);
      if (sample_valid && first < 0) first = k;
      vectors++; if (adc_clk !== m_adc) begin miscompares++; $display("FAIL c0_adc_clk k=%0d got=%b exp=%b", k, adc_clk, m_adc); end
    end
    vectors++; if (first != CAP + 3 * CLK_DIV + 2) begin miscompares++; $display("FAIL c0_first_valid got=%0d exp=%0d", first, CAP + 3 * CLK_DIV + 2); end
    vectors++; if (hi != CLK_DIV / 2) begin miscompares++; $display("FAIL c0_adc_high got=%0d exp=%0d", hi, CLK_DIV / 2); end
    vectors++; if (sample_data !== 8'h40) begin miscompares++; $display("FAIL c0_data got=%h exp=40", sample_data); end
    rdy = 1;
    for (int k = 61; k <= 150; k++) begin
      if (sample_valid) begin
        pops.push_back(k);
        vectors++; if (sample_data !== 8'h40) begin miscompares++; $display("FAIL c0_pop_data k=%0d got=%h exp=40", k, sample_data); end
      end
      step();
    end
    vectors++;
    if (pops.size() != 3) begin miscompares++; $display("FAIL c0_pop_count got=%0d exp=3", pops.size()); end
    else if (pops[2] - pops[1] != GRP * CLK_DIV) begin miscompares++; $display("FAIL c0_interval got=%0d exp=%0d", pops[2] - pops[1], GRP * CLK_DIV); end
  endtask

  task automatic test_rounding();
    logic [7:0] vals [8] = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h7F, 8'h80, 8'h80, 8'h80};
    logic [7:0] got[$];
    quiesce();
    rdy = 1; en = 1;
    for (int c = 0; c < 100; c++) begin
      din = (c / CLK_DIV < 8) ? vals[c / CLK_DIV] : 8'h80;
      if (sample_valid) got.push_back(sample_data);
      step();
      vectors++; if (sample_valid !== (m_q.size() != 0)) begin miscompares++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, sample_valid, m_q.size() != 0); end
    end
    vectors++;
    if (got.size() != 2) begin miscompares++; $display("FAIL round_count got=%0d exp=2", got.size()); end
    else begin
      if (got[0] !== 8'hFF) begin miscompares++; $display("FAIL round_grp1 got=%h exp=ff", got[0]); end
      vectors++;
      if (got[1] !== 8'hFF) begin miscompares++; $display("FAIL round_grp2 got=%h exp=ff", got[1]); end
    end
  endtask

  task automatic test_overflow();
    quiesce();
    din = 8'h90; rdy = 0; en = 1;
    for (int k = 1; k <= 240; k++) begin
      step();
      if (k == 237) begin
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_early got=%b exp=0", overflow); end
      end
      if (k == 238) begin
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_set got=%b exp=1", overflow); end
      end
    end
    vectors++; if (sample_valid !== 1'b1) begin miscompares++; $display("FAIL ovf_valid got=%b exp=1", sample_valid); end
    en = 0; clr = 1; rdy = 1;
    for (int i = 0; i < 4; i++) begin
      vectors++; if (sample_valid !== 1'b1 || sample_data !== 8'h10) begin miscompares++; $display("FAIL ovf_pop%0d got=%b/%h exp=1/10", i, sample_valid, sample_data); end
      step();
    end
    clr = 0;
    vectors++; if (sample_valid !== 1'b0) begin miscompares++; $display("FAIL ovf_drained got=%b exp=0", sample_valid); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_cleared got=%b exp=0", overflow); end
  endtask

  task automatic test_full_pop();
    logic [7:0] exp [4] = '{8'h10, 8'h10, 8'h10, 8'h20};
    quiesce();
    rdy = 0; en = 1;
    for (int k = 1; k <= 250; k++) begin
      din = (k - 1 < 16 * CLK_DIV) ? 8'h90 : 8'hA0;
      rdy = (k == CAP + 19 * CLK_DIV + 2);
      step();
    end
    en = 0; rdy = 0;
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL full_pop_ovf got=%b exp=0", overflow); end
    rdy = 1;
    for (int i = 0; i < 4; i++) begin
      vectors++; if (sample_valid !== 1'b1 || sample_data !== exp[i]) begin miscompares++; $display("FAIL full_pop_entry%0d got=%b/%h exp=1/%h", i, sample_valid, sample_data, exp[i]); end
      step();
    end
    vectors++; if (sample_valid !== 1'b0) begin miscompares++; $display("FAIL full_pop_count got=%b exp=0", sample_valid); end
    rdy = 0;
  endtask

  task automatic test_disable();
    quiesce();
    din = 8'hFF; rdy = 0; en = 1;
    repeat (26) step();
    vectors++; if (adc_clk !== 1'b1) begin miscompares++; $display("FAIL dis_pre_adc got=%b exp=1", adc_clk); end
    en = 0;
    step();
    vectors++; if (adc_clk !== 1'b0) begin miscompares++; $display("FAIL dis_adc_low got=%b exp=0", adc_clk); end
    repeat (2) step();
    din = 8'h80; en = 1;
    step();
    vectors++; if (adc_clk !== 1'b1) begin miscompares++; $display("FAIL dis_restart_adc got=%b exp=1", adc_clk); end
    repeat (49) step();
    vectors++; if (sample_valid !== 1'b1 || sample_data !== 8'h00) begin miscompares++; $display("FAIL dis_result got=%b/%h exp=1/00", sample_valid, sample_data); end
  endtask

  task automatic test_reset_mid();
    quiesce();
    din = 8'h90; rdy = 0; en = 1;
    repeat (110) step();
    vectors++; if (sample_valid !== 1'b1 || adc_clk !== 1'b1) begin miscompares++; $display("FAIL rmid_pre got=%b/%b exp=1/1", sample_valid, adc_clk); end
    rst_n = 0;
    #2;
    vectors++; if (sample_valid !== 1'b0 || adc_clk !== 1'b0 || overflow !== 1'b0 || sample_data !== 8'h00) begin
      miscompares++; $display("FAIL rmid_async got=%b/%b/%b/%h exp=0/0/0/00", sample_valid, adc_clk, overflow, sample_data);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1;
    for (int k = 1; k <= CAP + 3 * CLK_DIV + 2; k++) begin
      step();
      if (k == CAP + 3 * CLK_DIV + 1) begin
        vectors++; if (sample_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_early got=%b exp=0", sample_valid); end
      end
    end
    vectors++; if (sample_valid !== 1'b1 || sample_data !== 8'h10) begin miscompares++; $display("FAIL rmid_fresh got=%b/%h exp=1/10", sample_valid, sample_data); end
  endtask

  task automatic test_random();
    int dis;
    quiesce();
    dis = 0;
    for (int k = 0; k < 3000; k++) begin
      if (dis > 0) begin en = 0; dis--; end
      else begin en = 1; if ($urandom_range(0, 249) == 0) dis = $urandom_range(1, 5); end
      din = 8'($urandom);
      rdy = ((k % 600) < 300) ? 1'b0 : 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 49) == 0);
      step();
      vectors++; if (sample_valid !== (m_q.size() != 0)) begin miscompares++; $display("FAIL rand_valid k=%0d got=%b exp=%b", k, sample_valid, m_q.size() != 0); end
      vectors++; if (overflow !== m_ovf) begin miscompares++; $display("FAIL rand_ovf k=%0d got=%b exp=%b", k, overflow, m_ovf); end
      vectors++; if (adc_clk !== m_adc) begin miscompares++; $display("FAIL rand_adc k=%0d got=%b exp=%b", k, adc_clk, m_adc); end
      if (m_q.size() != 0) begin
        vectors++; if (sample_data !== m_q[0]) begin miscompares++; $display("FAIL rand_data k=%0d got=%h exp=%h", k, sample_data, m_q[0]); end
      end
    end
    clr = 0;
  endtask

  initial begin
    test_reset();
    test_const_c0();
    test_rounding();
    test_overflow();
    test_full_pop();
    test_disable();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
